// File: rtl/mem_pkg.sv
// Shared widths, state encoding and element types for the byte memory and
// its sequential writer/reader, so both ends agree on sizes.
package mem_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] byte_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   len_t;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} wr_state_t;
endpackage

// File: rtl/byte_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read
// port. A same-cycle read of the written address returns the old contents.
module byte_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/seq_mem_writer.sv
// Sequential fill engine: writes a valid/ready byte stream to consecutive
// addresses of an internal byte_ram, starting at a latched base and wrapping.
module seq_mem_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  import mem_pkg::*;

  typedef logic [ADDR_W:0] cnt_t;
  localparam int N_WORDS = 1 << ADDR_W;

  wr_state_t         state;
  logic [ADDR_W-1:0] wr_ptr;
  cnt_t              remaining;
  logic              hs;
  logic              we;

  // Requests beyond the array size saturate to one full pass.
  function automatic cnt_t clamp_len(input cnt_t l);
    return (l > cnt_t'(N_WORDS)) ? cnt_t'(N_WORDS) : l;
  endfunction

  assign hs = in_ready && in_valid;
  // Gating with reset keeps the aborting edge from committing a write.
  assign we = hs && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            wr_ptr    <= base_addr;
            remaining <= clamp_len(length);
            count     <= '0;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= WRITE;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (hs) begin
            wr_ptr    <= wr_ptr + 1'b1;
            remaining <= remaining - 1'b1;
            count     <= count + 1'b1;
            if (remaining == cnt_t'(1)) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  byte_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_seq_mem_writer.sv
// Directed bench for seq_mem_writer: a reference pointer/length model and a
// write scoreboard drained through the read port after each transfer.
module tb_seq_mem_writer;
  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [8:0] count;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] model [256];
  logic [7:0] m_ptr;
  int         m_rem;
  int         m_cnt;
  int         n_assert = 0;
  int         n_fail   = 0;

  seq_mem_writer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [7:0] base, input logic [8:0] len);
    start     = 1'b1;
    base_addr = base;
    length    = len;
    m_ptr     = base;
    m_rem     = (int'(len) > 256) ? 256 : int'(len);
    m_cnt     = 0;
    tick();
    start = 1'b0;
  endtask

  // Bit c of pat is in_valid in stream cycle c (all ones beyond bit 63).
  task automatic run_stream(input logic [63:0] pat, input int ncyc, input int d0);
    int  k;
    logic v;
    k = 0;
    for (int c = 0; c < ncyc; c++) begin
      v        = (c < 64) ? pat[c] : 1'b1;
      in_valid = v;
      in_data  = 8'(d0 + k);
      rd_addr  = m_ptr;
      #1;
      chk("in_ready", in_ready, 32'(m_rem > 0));
      chk("busy", busy, 32'(m_rem > 0));
      chk("count", count, m_cnt);
      chk("rd_old", rd_data, model[m_ptr]);
      if (v && m_rem > 0) begin
        sb.push_back('{addr: m_ptr, data: in_data});
        model[m_ptr] = in_data;
        m_ptr++;
        m_rem--;
        m_cnt++;
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_check();
    chk("done_pulse", done, 1);
    chk("ready_in_done", in_ready, 0);
    chk("busy_in_done", busy, 0);
    chk("count_final", count, m_cnt);
    tick();
    chk("done_low", done, 0);
    chk("busy_idle", busy, 0);
    chk("count_hold", count, m_cnt);
  endtask

  task automatic drain();
    wr_t e;
    while (sb.size() > 0) begin
      e       = sb.pop_front();
      rd_addr = e.addr;
      #1;
      chk("rd_data", rd_data, e.data);
    end
  endtask

  task automatic check_mem(input logic [7:0] a);
    rd_addr = a;
    #1;
    chk("mem_unchanged", rd_data, model[a]);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    in_valid = 1'b0; in_data = '0; rd_addr = '0;
    m_ptr = '0; m_rem = 0; m_cnt = 0;
    for (int i = 0; i < 256; i++) model[i] = 'x;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);

    // Basic fill
    do_start(8'd0, 9'd4);
    run_stream(64'hF, 4, 8'hA0);
    finish_check();
    drain();

    // Wrap at the top of the array
    do_start(8'd254, 9'd4);
    run_stream(64'hF, 4, 1);
    finish_check();
    drain();
    check_mem(8'd2);

    // Stalls: valid pattern 1,0,0,1,0,1
    do_start(8'd16, 9'd3);
    run_stream(64'b101001, 6, 8'h30);
    finish_check();
    drain();

    // Full sweep, length above 256 saturates to 256
    do_start(8'd0, 9'd300);
    run_stream(64'hFFFF_FFFF_FFFF_FFFF, 256, 0);
    finish_check();
    drain();
    chk("sweep_idle_ready", in_ready, 0);

    // Zero length
    do_start(8'd5, 9'd0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_ready", in_ready, 0);
    chk("zero_count", count, 0);
    tick();
    chk("zero_done_low", done, 0);
    check_mem(8'd5);

    // Start pulsed mid-transfer is ignored
    do_start(8'd40, 9'd3);
    run_stream(64'h1, 1, 8'h70);
    start     = 1'b1;
    base_addr = 8'd200;
    length    = 9'd5;
    tick();
    start = 1'b0;
    chk("ign_ready", in_ready, 1);
    chk("ign_count", count, 1);
    run_stream(64'h3, 2, 8'h71);
    finish_check();
    drain();
    check_mem(8'd200);

    // Reset mid-transfer with in_valid still high
    do_start(8'd60, 9'd8);
    run_stream(64'h7, 3, 8'h50);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    m_rem    = 0;
    chk("abort_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_count", count, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    drain();
    check_mem(8'd63);
    check_mem(8'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
